// File: rtl/inbox_fifo_pkg.sv
// Shared HRM CPU defaults: datapath width, inbox depth and the muxR source codes.
package inbox_fifo_pkg;

  localparam int HRM_WIDTH       = 8;
  localparam int HRM_INBOX_DEPTH = 16;

  typedef enum logic [1:0] {
    SRC_INBOX = 2'b00,
    SRC_MEM   = 2'b01,
    SRC_ALU   = 2'b11
  } mux_r_src_e;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH storage for the inbox queue: synchronous write, asynchronous read, no reset.
module fifo_mem_2p
  import inbox_fifo_pkg::*;
#(
  parameter int WIDTH = HRM_WIDTH,
  parameter int DEPTH = HRM_INBOX_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inbox_fifo.sv
// HRM CPU inbox: first-word-fall-through queue with sticky error flag.
// Define INBOX_LEVEL_EN to expose the occupancy on oLevel.
module inbox_fifo
  import inbox_fifo_pkg::*;
#(
  parameter int WIDTH = HRM_WIDTH,
  parameter int DEPTH = HRM_INBOX_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        iData,
  input  logic                    iWr,
  input  logic                    iRd,
  output logic signed [WIDTH-1:0] oData,
  output logic                    oEmpty,
  output logic                    oFull,
`ifdef INBOX_LEVEL_EN
  output logic [$clog2(DEPTH):0]  oLevel,
`endif
  output logic                    oErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] rd_data;
  logic             push_ok, pop_ok, err_now;

  assign oEmpty = (count == '0);
  assign oFull  = (count == FULL_CNT);

  // When full, a concurrent pop frees the head slot, which is exactly where wr_ptr points.
  assign push_ok = iWr && (!oFull || iRd);
  assign pop_ok  = iRd && !oEmpty;
  assign err_now = (iRd && oEmpty) || (iWr && oFull && !iRd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      oErr   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (err_now) oErr <= 1'b1;
    end
  end

  fifo_mem_2p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (iData),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign oData = oEmpty ? '0 : rd_data;

`ifdef INBOX_LEVEL_EN
  assign oLevel = count;
`endif

endmodule

// File: tb/tb_inbox_fifo.sv
// Directed self-checking bench for inbox_fifo; level checks run when INBOX_LEVEL_EN is defined.
module tb_inbox_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] data;
  logic       empty, full, err;
`ifdef INBOX_LEVEL_EN
  logic [4:0] level;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  inbox_fifo dut (
    .clk    (clk),
    .rst    (rst),
    .iData  (din),
    .iWr    (wr),
    .iRd    (rd),
    .oData  (data),
    .oEmpty (empty),
    .oFull  (full),
`ifdef INBOX_LEVEL_EN
    .oLevel (level),
`endif
    .oErr   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes; returns 1 ns after the edge with strobes released.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; din = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, 1'b0, d);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'b0, data}, {24'b0, exp});
    step(1'b0, 1'b1, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // 1: async reset without an edge
    #2 rst = 1'b1;
    #1;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full",  {31'b0, full},  32'd0);
    check("rst_err",   {31'b0, err},   32'd0);
    check("rst_data",  {24'b0, data},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: signed values in order
    push(8'h05); push(8'hFB); push(8'h7F);
    check("t2_not_empty", {31'b0, empty}, 32'd0);
    pop_check("t2_pop0", 8'h05);
    pop_check("t2_pop1", 8'hFB);
    pop_check("t2_pop2", 8'h7F);
    check("t2_empty", {31'b0, empty}, 32'd1);
    check("t2_data0", {24'b0, data},  32'd0);
    check("t2_err",   {31'b0, err},   32'd0);

    // 3: fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      check("t3_not_full", {31'b0, full}, 32'd0);
      push(8'(i));
    end
    check("t3_full", {31'b0, full}, 32'd1);
    check("t3_err0", {31'b0, err},  32'd0);
    push(8'h99);
    check("t3_err1",  {31'b0, err},  32'd1);
    check("t3_full2", {31'b0, full}, 32'd1);
    for (int i = 0; i < 16; i++) pop_check("t3_pop", 8'(i));
    check("t3_empty", {31'b0, empty}, 32'd1);
    check("t3_err_sticky", {31'b0, err}, 32'd1);

    // 4: pointer wrap
    do_reset();
    check("t4_err_clr", {31'b0, err}, 32'd0);
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int i = 0; i < 4; i++) pop_check("t4_popa", 8'(i));
    check("t4_not_full", {31'b0, full}, 32'd0);
    for (int i = 0; i < 4; i++) push(8'(100 + i));
    check("t4_full", {31'b0, full}, 32'd1);
    for (int i = 4; i < 16; i++) pop_check("t4_popb", 8'(i));
    for (int i = 0; i < 4; i++) pop_check("t4_popc", 8'(100 + i));
    check("t4_empty", {31'b0, empty}, 32'd1);
    check("t4_err",   {31'b0, err},   32'd0);

    // 5: simultaneous push+pop when full, then when empty
    do_reset();
    for (int i = 0; i < 16; i++) push(8'(i));
    step(1'b1, 1'b1, 8'hAA);
    check("t5_full_head", {24'b0, data}, 32'd1);
    check("t5_full_flag", {31'b0, full}, 32'd1);
    check("t5_full_err",  {31'b0, err},  32'd0);
    for (int i = 1; i < 16; i++) pop_check("t5_drain", 8'(i));
    pop_check("t5_drain_aa", 8'hAA);
    check("t5_empty", {31'b0, empty}, 32'd1);
    step(1'b1, 1'b1, 8'h33);
    check("t5_empty_err",  {31'b0, err},   32'd1);
    check("t5_empty_data", {24'b0, data},  32'd51);
    check("t5_one_word",   {31'b0, empty}, 32'd0);
    pop_check("t5_pop33", 8'h33);
    check("t5_empty2", {31'b0, empty}, 32'd1);

    // reset mid-operation discards the queue; next push lands at slot 0
    push(8'h11); push(8'h22);
    do_reset();
    check("rst_mid_empty", {31'b0, empty}, 32'd1);
    check("rst_mid_data",  {24'b0, data},  32'd0);
    push(8'h42);
    pop_check("rst_mid_pop", 8'h42);
    check("rst_mid_empty2", {31'b0, empty}, 32'd1);

`ifdef INBOX_LEVEL_EN
    // 6: occupancy tracking
    do_reset();
    check("t6_lvl0", {27'b0, level}, 32'd0);
    push(8'h01); check("t6_lvl1", {27'b0, level}, 32'd1);
    push(8'h02); check("t6_lvl2", {27'b0, level}, 32'd2);
    push(8'h03); check("t6_lvl3", {27'b0, level}, 32'd3);
    step(1'b0, 1'b1, 8'h00);
    check("t6_lvl4", {27'b0, level}, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
